// File: rtl/cdc_sync_flt_pkg.sv
// Shared definitions for the cdc_sync_flt multi-channel synchroniser/filter:
// legal parameter ranges and the filter counter width helper.
`timescale 1ns/1ps
package cdc_pkg;

  localparam int STAGE_MIN    = 2;
  localparam int STAGE_MAX    = 4;
  localparam int CHANNELS_MIN = 1;
  localparam int CHANNELS_MAX = 32;
  localparam int FILT_CNT_MIN = 1;
  localparam int FILT_CNT_MAX = 255;

  // One spare bit above $clog2 keeps FILT_CNT=1 at a legal 1-bit width.
  function automatic int flt_cnt_w(input int filt_cnt);
    return $clog2(filt_cnt) + 1;
  endfunction

endpackage

// File: rtl/cdc_sync_flt_if.sv
// Bundles the per-channel data, edge and control signals of cdc_sync_flt.
// CDC_SYNC_FLT_STICKY_EN adds the sticky event outputs and their clears.
`timescale 1ns/1ps
interface cdc_sync_flt_if #(parameter int CHANNELS = 4);

  logic                flt_en_i;
  logic [CHANNELS-1:0] dat_i;
  logic [CHANNELS-1:0] dat_o;
  logic [CHANNELS-1:0] rise_o;
  logic [CHANNELS-1:0] fall_o;
`ifdef CDC_SYNC_FLT_STICKY_EN
  logic [CHANNELS-1:0] evt_clr_i;
  logic [CHANNELS-1:0] evt_o;

  modport master (output flt_en_i, dat_i, evt_clr_i,
                  input  dat_o, rise_o, fall_o, evt_o);
  modport slave  (input  flt_en_i, dat_i, evt_clr_i,
                  output dat_o, rise_o, fall_o, evt_o);
`else
  modport master (output flt_en_i, dat_i,
                  input  dat_o, rise_o, fall_o);
  modport slave  (input  flt_en_i, dat_i,
                  output dat_o, rise_o, fall_o);
`endif

endinterface

// File: rtl/cdc_sync.sv
// STAGE-deep synchroniser chain built only from dffr flops, no logic between them.
`timescale 1ns/1ps
module cdc_sync #(
  parameter int                    DATA_WIDTH = 1,
  parameter int                    STAGE      = 2,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] chain [STAGE+1];

  assign chain[0] = d_i;

  for (genvar i = 0; i < STAGE; i++) begin : g_stage
    dffr #(.WIDTH(DATA_WIDTH), .RST_VAL(RST_VAL)) u_ff (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .d_i     (chain[i]),
      .q_o     (chain[i+1])
    );
  end

  assign q_o = chain[STAGE];

endmodule

// File: rtl/cdc_sync_flt_ch.sv
// One channel: synchroniser chain, consecutive-mismatch filter and registered
// rise/fall pulses derived from the filtered level.
`timescale 1ns/1ps
module cdc_sync_flt_ch
  import cdc_pkg::*;
#(
  parameter int   STAGE    = 2,
  parameter int   FILT_CNT = 4,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic flt_en_i,
  input  logic dat_i,
  output logic dat_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              CNT_W    = flt_cnt_w(FILT_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

  logic             sync_s;
  logic             q_d, q_q;
  logic             rise_d, rise_q;
  logic             fall_d, fall_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  cdc_sync #(.DATA_WIDTH(1), .STAGE(STAGE), .RST_VAL(RST_VAL)) u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (dat_i),
    .q_o     (sync_s)
  );

  // Any matching sample or bypass cycle restarts the mismatch count.
  always_comb begin
    q_d   = q_q;
    cnt_d = '0;
    if (!flt_en_i) begin
      q_d = sync_s;
    end else if (sync_s != q_q) begin
      if (cnt_q == CNT_LAST) q_d   = sync_s;
      else                   cnt_d = cnt_q + CNT_W'(1);
    end
    rise_d = q_d & ~q_q;
    fall_d = ~q_d & q_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_q    <= RST_VAL;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dat_o  = q_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/dffr.sv
// Plain register with asynchronous active-low reset to a parameterised value.
`timescale 1ns/1ps
module dffr #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) q_o <= RST_VAL;
    else          q_o <= d_i;
  end

endmodule

// File: rtl/cdc_sync_flt.sv
// Multi-channel synchroniser with glitch filter and edge pulses.
// Optional sticky event flags are built when CDC_SYNC_FLT_STICKY_EN is defined.
`timescale 1ns/1ps
module cdc_sync_flt
  import cdc_pkg::*;
#(
  parameter int                  STAGE    = 2,
  parameter int                  CHANNELS = 4,
  parameter int                  FILT_CNT = 4,
  parameter logic [CHANNELS-1:0] RST_VAL  = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  cdc_sync_flt_if.slave   bus
);

  if (STAGE < STAGE_MIN || STAGE > STAGE_MAX ||
      CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
      FILT_CNT < FILT_CNT_MIN || FILT_CNT > FILT_CNT_MAX) begin : g_bad_param
    $error("cdc_sync_flt: STAGE, CHANNELS or FILT_CNT outside legal range");
  end

  logic [CHANNELS-1:0] dat_w;
  logic [CHANNELS-1:0] rise_w;
  logic [CHANNELS-1:0] fall_w;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    cdc_sync_flt_ch #(
      .STAGE    (STAGE),
      .FILT_CNT (FILT_CNT),
      .RST_VAL  (RST_VAL[c])
    ) u_ch (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .flt_en_i (bus.flt_en_i),
      .dat_i    (bus.dat_i[c]),
      .dat_o    (dat_w[c]),
      .rise_o   (rise_w[c]),
      .fall_o   (fall_w[c])
    );
  end

  assign bus.dat_o  = dat_w;
  assign bus.rise_o = rise_w;
  assign bus.fall_o = fall_w;

`ifdef CDC_SYNC_FLT_STICKY_EN
  logic [CHANNELS-1:0] evt_d, evt_q;

  // A new edge pulse takes priority over a clear arriving in the same cycle.
  always_comb begin
    evt_d = rise_w | fall_w | (evt_q & ~bus.evt_clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) evt_q <= '0;
    else          evt_q <= evt_d;
  end

  assign bus.evt_o = evt_q;
`endif

endmodule

// File: tb/tb_cdc_sync_flt.sv
// Scoreboard bench for cdc_sync_flt: directed scenarios plus random traffic,
// checked against a sample-window reference model.
`timescale 1ns/1ps
module tb_cdc_sync_flt;

  localparam int         STAGE    = 2;
  localparam int         CHANNELS = 4;
  localparam int         FILT_CNT = 4;
  localparam logic [3:0] RST_VAL  = 4'b1010;

  typedef struct packed {
    logic [3:0] dat;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] evt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdc_sync_flt_if #(.CHANNELS(CHANNELS)) bus ();

  cdc_sync_flt #(
    .STAGE    (STAGE),
    .CHANNELS (CHANNELS),
    .FILT_CNT (FILT_CNT),
    .RST_VAL  (RST_VAL)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  exp_t       exp_q [$];
  logic [3:0] din_hist [$];
  bit         en_hist [$];
  logic [3:0] mq, mrise, mfall, mevt;
  int         last_chg [CHANNELS];
  int         n_checks = 0;
  int         n_pass = 0;
  bit         mon_en = 1'b0;
  logic [3:0] cur;

  // Value the filter sees at edge k: the input sampled STAGE edges earlier.
  function automatic logic [3:0] sync_at(input int k);
    if (k - STAGE >= 1) return din_hist[k-STAGE-1];
    return RST_VAL;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drives one cycle of inputs and pushes the model's prediction for the next edge.
  task automatic applyStimulus(input logic [3:0] din, input bit en, input logic [3:0] clr);
    int         n;
    logic [3:0] sn, sk, nq;
    bit         flip;
    exp_t       e;
    bus.dat_i    = din;
    bus.flt_en_i = en;
`ifdef CDC_SYNC_FLT_STICKY_EN
    bus.evt_clr_i = clr;
`endif
    din_hist.push_back(din);
    en_hist.push_back(en);
    n  = din_hist.size();
    sn = sync_at(n);
    nq = mq;
    for (int c = 0; c < CHANNELS; c++) begin
      if (!en) begin
        flip = (sn[c] != mq[c]);
      end else begin
        flip = 1'b1;
        for (int k = n - FILT_CNT + 1; k <= n; k++) begin
          if (k <= last_chg[c]) flip = 1'b0;
          else begin
            sk = sync_at(k);
            if (!en_hist[k-1] || sk[c] == mq[c]) flip = 1'b0;
          end
        end
      end
      if (flip) begin
        nq[c] = ~mq[c];
        last_chg[c] = n;
      end
    end
    mevt  = mrise | mfall | (mevt & ~clr);
    mrise = nq & ~mq;
    mfall = ~nq & mq;
    mq    = nq;
    e.dat = mq; e.rise = mrise; e.fall = mfall; e.evt = mevt;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold(input int cycles, input bit en);
    for (int i = 0; i < cycles; i++) applyStimulus(cur, en, 4'b0000);
  endtask

  initial begin : monitor
    exp_t e;
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("dat_o",  32'(bus.dat_o),  32'(e.dat));
        checkOutput("rise_o", 32'(bus.rise_o), 32'(e.rise));
        checkOutput("fall_o", 32'(bus.fall_o), 32'(e.fall));
        checkOutput("rise_fall_excl", 32'(bus.rise_o & bus.fall_o), 32'd0);
`ifdef CDC_SYNC_FLT_STICKY_EN
        checkOutput("evt_o", 32'(bus.evt_o), 32'(e.evt));
`endif
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin : stimulus
    int hold_len;
    mq = RST_VAL; mrise = '0; mfall = '0; mevt = '0;
    for (int c = 0; c < CHANNELS; c++) last_chg[c] = 0;
    bus.dat_i    = 4'b0101;
    bus.flt_en_i = 1'b1;
`ifdef CDC_SYNC_FLT_STICKY_EN
    bus.evt_clr_i = '0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset_dat_o",  32'(bus.dat_o),  32'(RST_VAL));
    checkOutput("reset_rise_o", 32'(bus.rise_o), 32'd0);
    checkOutput("reset_fall_o", 32'(bus.fall_o), 32'd0);
`ifdef CDC_SYNC_FLT_STICKY_EN
    checkOutput("reset_evt_o",  32'(bus.evt_o),  32'd0);
`endif
    $display("[TB] releasing reset");
    cur = RST_VAL;
    bus.dat_i = cur;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    hold(20, 1'b1);

    cur[0] = 1'b1;
    hold(10, 1'b1);

    cur[1] = ~cur[1]; hold(3, 1'b1);
    cur[1] = ~cur[1]; hold(8, 1'b1);
    cur[1] = ~cur[1]; hold(4, 1'b1);
    cur[1] = ~cur[1]; hold(10, 1'b1);

    cur[2] = ~cur[2]; hold(6, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cur[3] = ~cur[3];
      applyStimulus(cur, (i >= 3), 4'b0000);
    end
    hold(10, 1'b1);

    cur = 4'b0000; hold(10, 1'b1);
    cur = 4'b1111; hold(10, 1'b1);
    cur = 4'b0000; hold(10, 1'b1);

    $display("[TB] sticky event sequence");
    applyStimulus(cur, 1'b1, 4'b1111);
    cur[3] = 1'b1; hold(12, 1'b1);
    cur[3] = 1'b0;
    for (int i = 0; i < 12; i++) applyStimulus(cur, 1'b1, (i == 6) ? 4'b1000 : 4'b0000);
    hold(3, 1'b1);
    applyStimulus(cur, 1'b1, 4'b1000);
    hold(3, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) cur[$urandom_range(0, CHANNELS-1)] ^= 1'b1;
      hold_len = $urandom_range(1, 6);
      for (int j = 0; j < hold_len; j++)
        applyStimulus(cur, ($urandom_range(0, 7) != 0),
                      ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000);
    end
    hold(8, 1'b1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
